// File: rtl/cpu_pkg.sv
// Shared CPU types for the post-commit store buffer: widths, entry layout and FSM states.
package cpu_pkg;

  localparam int unsigned SB_AW = 7;
  localparam int unsigned SB_DW = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  typedef enum logic {
    SB_RUN,
    SB_FENCE
  } sb_state_e;

endpackage

// File: rtl/sb_fwd_match.sv
// Age-ordered forwarding select: youngest matching store (incoming first, then tail-1 .. head).
module sb_fwd_match
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  sb_entry_t        entries_i [DEPTH],
  input  logic [DEPTH-1:0] valid_i,
  input  logic [PW-1:0]    head_i,
  input  logic             inc_valid_i,
  input  sb_entry_t        inc_i,
  input  logic [AW-1:0]    ld_addr_i,
  output logic             hit_o,
  output logic [DW-1:0]    data_o
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if (valid_i[idx] && (entries_i[idx].addr == ld_addr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
    if (inc_valid_i && (inc_i.addr == ld_addr_i)) begin
      hit_o  = 1'b1;
      data_o = inc_i.data;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: FIFO of retired stores drained to dm, with load forwarding and fence.
module store_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned AW             = SB_AW,
  parameter int unsigned DW             = SB_DW,
  parameter bit          ProtocolAssert = 1'b1,
  localparam int unsigned PW            = $clog2(DEPTH),
  localparam int unsigned CW            = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          sb_full,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_fwd_hit,
  output logic [DW-1:0] ld_fwd_data,
  input  logic          dm_wr_ready,
  output logic          dm_wr,
  output logic [AW-1:0] dm_waddr,
  output logic [DW-1:0] dm_wdata,
  input  logic          fence_req,
  output logic          fence_done,
  output logic          sb_empty,
  output logic [CW-1:0] sb_count
);

  sb_state_e        state_q, state_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             fence_done_q, fence_done_d;
  sb_entry_t        mem_q [DEPTH];
  sb_entry_t        inc_entry;
  logic             enq, deq;
  logic             st_overrun;

  assign inc_entry.addr = st_addr;
  assign inc_entry.data = st_data;

  // Full/empty come from registered state only: a drain at full never frees a slot same-cycle.
  assign sb_empty   = (count_q == '0);
  assign sb_full    = (count_q == CW'(DEPTH)) || (state_q == SB_FENCE);
  assign enq        = st_valid && !sb_full;
  assign deq        = !sb_empty && dm_wr_ready;
  assign st_overrun = st_valid && sb_full;

  assign dm_wr      = deq;
  assign dm_waddr   = mem_q[head_q].addr;
  assign dm_wdata   = mem_q[head_q].data;
  assign sb_count   = count_q;
  assign fence_done = fence_done_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    count_d = count_q + CW'(enq) - CW'(deq);
    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end
  end

  // fence_done is registered, so it rises in the cycle where sb_count first reads 0.
  always_comb begin
    state_d      = state_q;
    fence_done_d = 1'b0;
    unique case (state_q)
      SB_RUN: begin
        if (fence_req) begin
          if ((count_q != '0) || enq) begin
            state_d = SB_FENCE;
          end else begin
            fence_done_d = 1'b1;
          end
        end
      end
      SB_FENCE: begin
        if (count_d == '0) begin
          state_d      = SB_RUN;
          fence_done_d = 1'b1;
        end
      end
      default: state_d = SB_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SB_RUN;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      fence_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      fence_done_q <= fence_done_d;
    end
  end

  // Payload storage needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[tail_q] <= inc_entry;
    end
  end

  sb_fwd_match #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fwd (
    .entries_i  (mem_q),
    .valid_i    (valid_q),
    .head_i     (head_q),
    .inc_valid_i(enq),
    .inc_i      (inc_entry),
    .ld_addr_i  (ld_addr),
    .hit_o      (ld_fwd_hit),
    .data_o     (ld_fwd_data)
  );

  if (ProtocolAssert) begin : g_proto_assert
    assert property (@(posedge clk) disable iff (!rst) !st_overrun)
      else $error("store_buffer: st_valid asserted while sb_full");
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: scoreboard of expected dm drains plus per-step output checks.
module tb_store_buffer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic [6:0]  st_addr = '0;
  logic [31:0] st_data = '0;
  logic        sb_full;
  logic [6:0]  ld_addr = '0;
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;
  logic        dm_wr_ready = 1'b0;
  logic        dm_wr;
  logic [6:0]  dm_waddr;
  logic [31:0] dm_wdata;
  logic        fence_req = 1'b0;
  logic        fence_done;
  logic        sb_empty;
  logic [2:0]  sb_count;

  int checks = 0;
  int errors = 0;
  int drains = 0;
  sb_entry_t exp_q[$];

  store_buffer #(
    .DEPTH         (4),
    .AW            (7),
    .DW            (32),
    .ProtocolAssert(1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .sb_full    (sb_full),
    .ld_addr    (ld_addr),
    .ld_fwd_hit (ld_fwd_hit),
    .ld_fwd_data(ld_fwd_data),
    .dm_wr_ready(dm_wr_ready),
    .dm_wr      (dm_wr),
    .dm_waddr   (dm_waddr),
    .dm_wdata   (dm_wdata),
    .fence_req  (fence_req),
    .fence_done (fence_done),
    .sb_empty   (sb_empty),
    .sb_count   (sb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_st(input logic [6:0] a, input logic [31:0] d, input bit accept);
    sb_entry_t e;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    if (accept) begin
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
    end
  endtask

  // Drain monitor: every dm write must match the oldest outstanding accepted store.
  always @(negedge clk) begin
    sb_entry_t e;
    if (rst && dm_wr) begin
      drains++;
      chk("drain_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("drain_addr", 64'(dm_waddr), 64'(e.addr));
        chk("drain_data", 64'(dm_wdata), 64'(e.data));
      end
    end
  end

  initial begin
    int d0;
    // Reset values, with dm ready so a bad count would show up as a drain.
    dm_wr_ready = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_empty", 64'(sb_empty), 64'd1);
    chk("rst_full", 64'(sb_full), 64'd0);
    chk("rst_count", 64'(sb_count), 64'd0);
    chk("rst_dm_wr", 64'(dm_wr), 64'd0);
    chk("rst_hit", 64'(ld_fwd_hit), 64'd0);
    chk("rst_fence_done", 64'(fence_done), 64'd0);
    #20 rst = 1'b1;
    dm_wr_ready = 1'b0;
    tick();

    // Fill to full, try a fifth store, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      drive_st(7'(i), 32'hA0 + 32'(i), 1'b1);
      tick();
    end
    st_valid = 1'b0;
    #1;
    chk("fill_count", 64'(sb_count), 64'd4);
    chk("fill_full", 64'(sb_full), 64'd1);
    drive_st(7'd9, 32'hEE, 1'b0);
    #1;
    chk("fill_overrun_flag", 64'(dut.st_overrun), 64'd1);
    tick();
    st_valid = 1'b0;
    #1;
    chk("fill_refused_count", 64'(sb_count), 64'd4);
    d0 = drains;
    dm_wr_ready = 1'b1;
    repeat (4) tick();
    dm_wr_ready = 1'b0;
    #1;
    chk("fill_drain_cnt", 64'(drains - d0), 64'd4);
    chk("fill_drained_empty", 64'(sb_empty), 64'd1);

    // Forwarding priority: youngest buffered, then incoming overrides.
    drive_st(7'd5, 32'h11, 1'b1);
    tick();
    drive_st(7'd5, 32'h22, 1'b1);
    tick();
    st_valid = 1'b0;
    ld_addr  = 7'd5;
    #1;
    chk("fwd_hit_buf", 64'(ld_fwd_hit), 64'd1);
    chk("fwd_data_buf", 64'(ld_fwd_data), 64'h22);
    drive_st(7'd5, 32'h33, 1'b1);
    #1;
    chk("fwd_data_inc", 64'(ld_fwd_data), 64'h33);
    ld_addr = 7'd6;
    #1;
    chk("fwd_miss_hit", 64'(ld_fwd_hit), 64'd0);
    chk("fwd_miss_data", 64'(ld_fwd_data), 64'd0);
    tick();
    st_valid    = 1'b0;
    ld_addr     = 7'd5;
    dm_wr_ready = 1'b1;
    #1;
    chk("fwd_while_drain", 64'(ld_fwd_data), 64'h33);
    repeat (3) tick();
    dm_wr_ready = 1'b0;
    ld_addr     = 7'd0;
    #1;
    chk("fwd_drained_empty", 64'(sb_empty), 64'd1);

    // Drain latency and enqueue+drain at count 1.
    dm_wr_ready = 1'b1;
    drive_st(7'h10, 32'h55, 1'b1);
    #1;
    chk("lat_no_bypass", 64'(dm_wr), 64'd0);
    tick();
    drive_st(7'h11, 32'h66, 1'b1);
    #1;
    chk("ed_dm_wr", 64'(dm_wr), 64'd1);
    chk("ed_old_addr", 64'(dm_waddr), 64'h10);
    tick();
    st_valid    = 1'b0;
    dm_wr_ready = 1'b0;
    #1;
    chk("ed_count", 64'(sb_count), 64'd1);
    dm_wr_ready = 1'b1;
    tick();
    dm_wr_ready = 1'b0;
    #1;
    chk("ed_empty", 64'(sb_empty), 64'd1);

    // Full with a same-cycle drain still refuses the store.
    for (int i = 0; i < 4; i++) begin
      drive_st(7'h20 + 7'(i), 32'hB0 + 32'(i), 1'b1);
      tick();
    end
    dm_wr_ready = 1'b1;
    ld_addr     = 7'h7F;
    drive_st(7'h7F, 32'hFF, 1'b0);
    #1;
    chk("fd_full", 64'(sb_full), 64'd1);
    chk("fd_no_fwd", 64'(ld_fwd_hit), 64'd0);
    tick();
    st_valid = 1'b0;
    ld_addr  = 7'd0;
    #1;
    chk("fd_count", 64'(sb_count), 64'd3);
    repeat (3) tick();
    dm_wr_ready = 1'b0;
    #1;
    chk("fd_empty", 64'(sb_empty), 64'd1);

    // Fence with two entries, dm stalled three cycles.
    drive_st(7'h30, 32'hC0, 1'b1);
    tick();
    drive_st(7'h31, 32'hC1, 1'b1);
    tick();
    st_valid  = 1'b0;
    fence_req = 1'b1;
    #1;
    chk("fence_req_full", 64'(sb_full), 64'd0);
    tick();
    fence_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) fence_req = 1'b1;
      #1;
      chk("fence_stall_full", 64'(sb_full), 64'd1);
      chk("fence_stall_done", 64'(fence_done), 64'd0);
      tick();
      fence_req = 1'b0;
    end
    dm_wr_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("fence_drain_full", 64'(sb_full), 64'd1);
      chk("fence_drain_done", 64'(fence_done), 64'd0);
      tick();
    end
    dm_wr_ready = 1'b0;
    #1;
    chk("fence_done_pulse", 64'(fence_done), 64'd1);
    chk("fence_done_count", 64'(sb_count), 64'd0);
    chk("fence_done_unfull", 64'(sb_full), 64'd0);
    tick();
    #1;
    chk("fence_done_single", 64'(fence_done), 64'd0);

    // Fence on an empty buffer completes the next cycle.
    fence_req = 1'b1;
    tick();
    fence_req = 1'b0;
    #1;
    chk("fence_empty_done", 64'(fence_done), 64'd1);
    tick();
    #1;
    chk("fence_empty_single", 64'(fence_done), 64'd0);
    chk("sb_all_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with three entries buffered.
    for (int i = 0; i < 3; i++) begin
      drive_st(7'h40 + 7'(i), 32'hD0 + 32'(i), 1'b1);
      tick();
    end
    st_valid    = 1'b0;
    dm_wr_ready = 1'b1;
    #1;
    chk("pre_rst_dm_wr", 64'(dm_wr), 64'd1);
    chk("pre_rst_count", 64'(sb_count), 64'd3);
    rst = 1'b0;
    #1;
    chk("arst_empty", 64'(sb_empty), 64'd1);
    chk("arst_count", 64'(sb_count), 64'd0);
    chk("arst_dm_wr", 64'(dm_wr), 64'd0);
    exp_q.delete();
    #10 rst = 1'b1;
    tick();
    #1;
    chk("post_rst_count", 64'(sb_count), 64'd0);
    chk("post_rst_dm_wr", 64'(dm_wr), 64'd0);
    dm_wr_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
